// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: S-box, round constants, byte/word helpers and
// the 4x4 byte state type used by every pipeline stage.
package aes_pkg;

  localparam int BLK_W = 128;
  localparam int LAT   = 11;

  // State indexed [column][row]; element [0][0] is the most significant byte,
  // so a 128-bit block casts straight onto the column-major AES state.
  typedef logic [0:3][0:3][7:0] state_t;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

endpackage

// File: rtl/aes_round.sv
// One AES round as a pipeline stage: derives this round's key from the
// previous one, applies SubBytes/ShiftRows/(MixColumns)/AddRoundKey and
// registers state, round key and valid together so each block owns its key.
module aes_round
  import aes_pkg::*;
#(
  parameter int ROUND = 1,
  parameter bit FINAL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  state_t            state_i,
  input  logic [0:3][31:0]  key_i,
  output logic              valid_o,
  output state_t            state_o,
  output logic [0:3][31:0]  key_o
);

  logic [31:0]      temp_w;
  logic [0:3][31:0] key_d, key_q;
  state_t           sub_b, shift_r, mix_c, state_d, state_q;
  logic             valid_q;

  // Key expansion step: the four words for this round from the previous four.
  always_comb begin
    temp_w   = sub_word(rot_word(key_i[3])) ^ {RCON[ROUND], 24'h000000};
    key_d[0] = key_i[0] ^ temp_w;
    key_d[1] = key_i[1] ^ key_d[0];
    key_d[2] = key_i[2] ^ key_d[1];
    key_d[3] = key_i[3] ^ key_d[2];
  end

  // Round transform; the last round skips MixColumns.
  always_comb begin
    sub_b   = '0;
    shift_r = '0;
    mix_c   = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sub_b[c][r] = SBOX[state_i[c][r]];
      end
    end
    // Row r rotates left by r columns.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shift_r[c][r] = sub_b[(c + r) % 4][r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mix_c[c][0] = xtime(shift_r[c][0]) ^ xtime(shift_r[c][1]) ^ shift_r[c][1] ^ shift_r[c][2] ^ shift_r[c][3];
      mix_c[c][1] = shift_r[c][0] ^ xtime(shift_r[c][1]) ^ xtime(shift_r[c][2]) ^ shift_r[c][2] ^ shift_r[c][3];
      mix_c[c][2] = shift_r[c][0] ^ shift_r[c][1] ^ xtime(shift_r[c][2]) ^ xtime(shift_r[c][3]) ^ shift_r[c][3];
      mix_c[c][3] = xtime(shift_r[c][0]) ^ shift_r[c][0] ^ shift_r[c][1] ^ shift_r[c][2] ^ xtime(shift_r[c][3]);
    end
    if (FINAL) begin
      state_d = shift_r ^ key_d;
    end else begin
      state_d = mix_c ^ key_d;
    end
  end

  // Stage register: data loads every cycle, bubbles just carry valid = 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      key_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      valid_q <= valid_i;
    end
  end

  assign state_o = state_q;
  assign key_o   = key_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/aes_cipher.sv
// Fully pipelined AES-128 encryptor: stage 0 does the initial AddRoundKey,
// ten aes_round stages follow, one block per clock, latency 11 cycles.
// Optional macro AES_CIPHER_GATE_EN zeroes `out` whenever valid_out is low.
module aes_cipher
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [0:127]     in,
  input  logic [0:Nk*32-1] key,
  output logic [0:127]     out,
  output logic             valid_out
);

  if (Nk != 4) begin : g_bad_nk
    $error("aes_cipher: Nk must be 4");
  end
  if (Nr != Nk + 6) begin : g_bad_nr
    $error("aes_cipher: Nr must equal Nk+6");
  end

  state_t           stage_state [0:10];
  logic [0:3][31:0] stage_key   [0:10];
  logic             stage_valid [0:10];

  state_t           st0_d, st0_q;
  logic [0:3][31:0] key0_q;
  logic             vld0_q;

  // Initial AddRoundKey with the cipher key itself.
  always_comb begin
    st0_d = in ^ key;
  end

  // Stage 0 register: whitened state, key words w0..w3 and valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st0_q  <= '0;
      key0_q <= '0;
      vld0_q <= 1'b0;
    end else begin
      st0_q  <= st0_d;
      key0_q <= key;
      vld0_q <= valid_in;
    end
  end

  assign stage_state[0] = st0_q;
  assign stage_key[0]   = key0_q;
  assign stage_valid[0] = vld0_q;

  for (genvar i = 1; i <= Nr; i++) begin : g_round
    aes_round #(
      .ROUND (i),
      .FINAL (i == Nr)
    ) u_round (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (stage_valid[i-1]),
      .state_i (stage_state[i-1]),
      .key_i   (stage_key[i-1]),
      .valid_o (stage_valid[i]),
      .state_o (stage_state[i]),
      .key_o   (stage_key[i])
    );
  end

  assign valid_out = stage_valid[10];
`ifdef AES_CIPHER_GATE_EN
  assign out = stage_state[10] & {BLK_W{stage_valid[10]}};
`else
  assign out = stage_state[10];
`endif

endmodule

// File: tb/tb_aes_cipher.sv
// Self-checking bench for aes_cipher: known-answer vectors pushed into a
// timed scoreboard on drive, popped and compared when valid_out rises.
module tb_aes_cipher;

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
  } vec_t;

  typedef struct {
    int           due;
    logic [127:0] exp;
  } sb_t;

  logic         clk;
  logic         rst_n;
  logic         valid_in;
  logic [0:127] din;
  logic [0:127] dkey;
  logic [0:127] dout;
  logic         valid_out;

  int  cyc;
  int  n_tests;
  int  n_fail;
  sb_t sb [$];
  sb_t head;
  vec_t tbl [5];

  aes_cipher #(.Nk(4), .Nr(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .in        (din),
    .key       (dkey),
    .out       (dout),
    .valid_out (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every valid output must match the oldest pending block on time.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        head = sb.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL overdue: valid_out missing at cycle %0d, required %h", head.due, head.exp);
      end
      if (valid_out) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_valid: cycle %0d out=%h, required no output", cyc, dout);
        end else begin
          head = sb.pop_front();
          if (head.due != cyc || dout != head.exp) begin
            n_fail++;
            $display("FAIL ct: cycle %0d out=%h, required %h at cycle %0d", cyc, dout, head.exp, head.due);
          end
        end
      end else begin
`ifdef AES_CIPHER_GATE_EN
        n_tests++;
        if (dout != 128'h0) begin
          n_fail++;
          $display("FAIL gate: cycle %0d out=%h, required 0", cyc, dout);
        end
`endif
      end
    end
  end

  task automatic drive(input logic v, input logic [127:0] pt, input logic [127:0] k,
                       input logic [127:0] exp);
    sb_t e;
    @(negedge clk);
    valid_in = v;
    din      = pt;
    dkey     = k;
    if (v) begin
      e.due = cyc + 11;
      e.exp = exp;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    drive(1'b0, 128'h0, 128'h0, 128'h0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() > 0; i++) begin
      @(negedge clk);
    end
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d blocks still pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_reset(input string tag);
    n_tests++;
    if (valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_valid: valid_out=%b, required 0", tag, valid_out);
    end
    n_tests++;
    if (dout !== 128'h0) begin
      n_fail++;
      $display("FAIL %s_out: out=%h, required 0", tag, dout);
    end
  endtask

  localparam logic [127:0] K0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 = 128'h0a940bb5416ef045f1c39458c653ea5a;

  initial begin
    cyc = 0; n_tests = 0; n_fail = 0;
    tbl[0] = '{pt: K0, key: K0, ct: CT1};
    tbl[1] = '{pt: 128'h0, key: K0, ct: 128'hc6a13b37878f5b826f4f8162a1c8d879};
    tbl[2] = '{pt: 128'h00112233445566778899aabbccddeeff, key: K0,
               ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    tbl[3] = '{pt: 128'h3243f6a8885a308d313198a2e0370734, key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
               ct: 128'h3925841d02dc09fbdc118597196a0b32};
    tbl[4] = '{pt: 128'h0, key: 128'h0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    rst_n = 1'b0; valid_in = 1'b0; din = '0; dkey = '0;
    #1;
    check_reset("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Vector 1 followed immediately by the pipelined zero-plaintext pair.
    drive(1'b1, tbl[0].pt, tbl[0].key, tbl[0].ct);
    drive(1'b1, tbl[1].pt, tbl[1].key, tbl[1].ct);
    idle();
    drive(1'b1, tbl[2].pt, tbl[2].key, tbl[2].ct);
    idle();
    drain();

    // Whole table back-to-back, differing keys in consecutive cycles.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, tbl[i].pt, tbl[i].key, tbl[i].ct);
    end
    // Identical inputs on consecutive cycles.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, tbl[3].pt, tbl[3].key, tbl[3].ct);
    end
    idle();
    drain();

    // Mid-stream reset: blocks in flight are discarded and never reappear.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, tbl[i].pt, tbl[i].key, tbl[i].ct);
    end
    idle();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, tbl[0].pt, tbl[0].key, tbl[0].ct);
    idle();
    drain();
    repeat (14) @(negedge clk);

    // Bubbles: alternating valid pattern must reappear 11 cycles later.
    for (int i = 0; i < 10; i++) begin
      drive((i % 2) == 0, tbl[i % 5].pt, tbl[i % 5].key, tbl[i % 5].ct);
    end
    idle();
    drain();
    repeat (14) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
